// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types, fixed-point helpers and twiddle generator for the R2SDF FFT
package fft_pkg;

    localparam int DW_DEF = 16;
    localparam int TW_DEF = 16;

    typedef struct packed {
        logic signed [DW_DEF-1:0] re;
        logic signed [DW_DEF-1:0] im;
    } cpx_t;

    function automatic longint sat(input longint v, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Round half up while dropping sh LSBs; sh must be at least 1.
    function automatic longint round_shift(input longint v, input int sh);
        return (v + (longint'(1) <<< (sh - 1))) >>> sh;
    endfunction

    // Quantised cos (im_part=0) or -sin (im_part=1) of 2*pi*k/2^log2n in Q1.(tw-1).
    function automatic int twiddle(input int k, input int log2n, input int tw, input bit im_part);
        real ang;
        real v;
        int  full;
        int  q;
        ang  = 2.0 * 3.14159265358979323846 * real'(k) / real'(1 << log2n);
        v    = im_part ? -$sin(ang) : $cos(ang);
        full = 1 << (tw - 1);
        q    = int'($floor(v * real'(full) + 0.5));
        if (q > full - 1) q = full - 1;
        return q;
    endfunction

endpackage

// File: rtl/r2sdf_twiddle_rom.sv
// rtl/r2sdf_twiddle_rom.sv - combinational W_N^k table, cos/-sin fixed at elaboration
module r2sdf_twiddle_rom
    import fft_pkg::*;
#(
    parameter int LOG2N = 3,
    parameter int TW    = TW_DEF,
    parameter int KW    = 2
) (
    input  logic [KW-1:0]        k,
    output logic signed [TW-1:0] w_re,
    output logic signed [TW-1:0] w_im
);

    logic signed [TW-1:0] rom_re [2**KW];
    logic signed [TW-1:0] rom_im [2**KW];

    for (genvar i = 0; i < 2**KW; i++) begin : g_rom
        assign rom_re[i] = TW'(twiddle(i, LOG2N, TW, 1'b0));
        assign rom_im[i] = TW'(twiddle(i, LOG2N, TW, 1'b1));
    end

    assign w_re = rom_re[k];
    assign w_im = rom_im[k];

endmodule

// File: rtl/r2sdf_stage_fx.sv
// rtl/r2sdf_stage_fx.sv - radix-2 SDF FFT stage; define R2SDF_SCALE_EN for halving butterflies
module r2sdf_stage_fx
    import fft_pkg::*;
#(
    parameter int LOG2N = 3,
    parameter int STAGE = 1,
    parameter int DW    = DW_DEF,
    parameter int TW    = TW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_start,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic                 out_valid,
    output logic                 out_start,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im
);

    localparam int C  = LOG2N - STAGE + 1;
    localparam int D  = 1 << (C - 1);
    localparam int KW = (LOG2N > 1) ? LOG2N - 1 : 1;

    logic [C-1:0]         cnt, idx;
    logic                 primed, phase_b, primed_now;
    logic [KW-1:0]        k;
    logic signed [TW-1:0] w_re, w_im;
    logic signed [DW-1:0] head_re, head_im, fifo_re, fifo_im, res_re, res_im;
    longint               p_re, p_im;

    function automatic logic signed [DW-1:0] bfly(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b,
                                                  input logic sub);
        longint t;
        t = sub ? longint'(a) - longint'(b) : longint'(a) + longint'(b);
`ifdef R2SDF_SCALE_EN
        return DW'(round_shift(t, 1));
`else
        return DW'(sat(t, DW));
`endif
    endfunction

    always_comb begin
        idx        = in_start ? '0 : cnt;
        phase_b    = idx[C-1];
        primed_now = phase_b | (primed & ~in_start);
    end

    // The twiddle index follows the difference leaving the FIFO, i.e. this sample's low count bits.
    if (STAGE == LOG2N) begin : g_k_zero
        assign k = '0;
    end else begin : g_k
        assign k = KW'(idx[C-2:0]) << (STAGE - 1);
    end

    r2sdf_twiddle_rom #(.LOG2N(LOG2N), .TW(TW), .KW(KW)) u_rom (
        .k    (k),
        .w_re (w_re),
        .w_im (w_im)
    );

    always_comb begin
        res_re  = head_re;
        res_im  = head_im;
        fifo_re = in_re;
        fifo_im = in_im;
        p_re    = longint'(head_re) * longint'(w_re) - longint'(head_im) * longint'(w_im);
        p_im    = longint'(head_re) * longint'(w_im) + longint'(head_im) * longint'(w_re);
        if (phase_b) begin
            res_re  = bfly(head_re, in_re, 1'b0);
            res_im  = bfly(head_im, in_im, 1'b0);
            fifo_re = bfly(head_re, in_re, 1'b1);
            fifo_im = bfly(head_im, in_im, 1'b1);
        end else if (k != '0) begin
            res_re = DW'(sat(round_shift(p_re, TW - 1), DW));
            res_im = DW'(sat(round_shift(p_im, TW - 1), DW));
        end
    end

    if (D <= 4) begin : g_sr
        logic signed [DW-1:0] sr_re [D];
        logic signed [DW-1:0] sr_im [D];
        always_ff @(posedge clk) begin
            if (in_valid) begin
                sr_re[0] <= fifo_re;
                sr_im[0] <= fifo_im;
                for (int i = 1; i < D; i++) begin
                    sr_re[i] <= sr_re[i-1];
                    sr_im[i] <= sr_im[i-1];
                end
            end
        end
        assign head_re = sr_re[D-1];
        assign head_im = sr_im[D-1];
    end else begin : g_ram
        localparam int PW = $clog2(D);
        logic signed [DW-1:0] mem_re [D];
        logic signed [DW-1:0] mem_im [D];
        logic [PW-1:0]        ptr;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)        ptr <= '0;
            else if (in_valid) ptr <= ptr + PW'(1);
        end
        // Read-before-write on one pointer: the slot read now is the oldest of D entries.
        always_ff @(posedge clk) begin
            if (in_valid) begin
                mem_re[ptr] <= fifo_re;
                mem_im[ptr] <= fifo_im;
            end
        end
        assign head_re = mem_re[ptr];
        assign head_im = mem_im[ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            primed    <= 1'b0;
            out_valid <= 1'b0;
            out_start <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            out_valid <= 1'b0;
            out_start <= 1'b0;
            if (in_valid) begin
                cnt       <= idx + C'(1);
                primed    <= primed_now;
                out_valid <= primed_now;
                out_start <= (idx == C'(D));
                out_re    <= res_re;
                out_im    <= res_im;
            end
        end
    end

endmodule

// File: tb/tb_r2sdf_stage_fx.sv
// tb/tb_r2sdf_stage_fx.sv - self-checking bench for r2sdf_stage_fx (STAGE=1 and STAGE=3 side by side)
module tb_r2sdf_stage_fx;
    import fft_pkg::*;

    localparam int LOG2N = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_start = 1'b0;
    logic signed [15:0] in_re = '0;
    logic signed [15:0] in_im = '0;
    logic               o1_valid, o1_start, o3_valid, o3_start;
    logic signed [15:0] o1_re, o1_im, o3_re, o3_im;

    int total = 0;
    int bad   = 0;

    r2sdf_stage_fx #(.LOG2N(LOG2N), .STAGE(1), .DW(16), .TW(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_start(in_start),
        .in_re(in_re), .in_im(in_im), .out_valid(o1_valid), .out_start(o1_start),
        .out_re(o1_re), .out_im(o1_im));

    r2sdf_stage_fx #(.LOG2N(LOG2N), .STAGE(3), .DW(16), .TW(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_start(in_start),
        .in_re(in_re), .in_im(in_im), .out_valid(o3_valid), .out_start(o3_start),
        .out_re(o3_re), .out_im(o3_im));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

`ifdef R2SDF_SCALE_EN
    localparam int SUM2 = 1000;
    localparam int S3   = 500;
    localparam int TW3  = 354;
`else
    localparam int SUM2 = 2000;
    localparam int S3   = 1000;
    localparam int TW3  = 707;
`endif

    // Reference: sample n of a frame (counted from the last start) and its history.
    int n_cnt = 0;
    int h_re [16];
    int h_im [16];
    bit hk [2];
    int hr [2];
    int hi [2];
    int ht [2];

    function automatic int bf(input int a, input int b, input bit sub);
        longint t;
        t = sub ? longint'(a) - longint'(b) : longint'(a) + longint'(b);
`ifdef R2SDF_SCALE_EN
        return int'($floor((real'(t) + 1.0) / 2.0));
`else
        if (t > 32767) return 32767;
        if (t < -32768) return -32768;
        return int'(t);
`endif
    endfunction

    function automatic int qtw(input int k, input bit im_part);
        real a;
        real v;
        int q;
        a = 2.0 * 3.14159265358979323846 * real'(k) / 8.0;
        v = im_part ? -$sin(a) : $cos(a);
        q = int'($floor(v * 32768.0 + 0.5));
        if (q > 32767) q = 32767;
        return q;
    endfunction

    function automatic int rsat(input longint p);
        int q;
        q = int'($floor(real'(p) / 32768.0 + 0.5));
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    // Phase B: sum of x[n-D] and x[n]. Phase F (n>=2D): twiddled difference of x[n-2D], x[n-D].
    function automatic void model(input int s, input int n, output bit v, output bit st,
                                  output int re, output int im, output int tol);
        int d, p, k, dr, di, c, ns;
        d = 1 << (LOG2N - s);
        p = n % (2 * d);
        v = 0; st = 0; re = 0; im = 0; tol = 0;
        if (p >= d) begin
            v  = 1;
            st = (p == d);
            re = bf(h_re[(n - d) & 15], h_re[n & 15], 1'b0);
            im = bf(h_im[(n - d) & 15], h_im[n & 15], 1'b0);
        end else if (n >= 2 * d) begin
            v  = 1;
            dr = bf(h_re[(n - 2 * d) & 15], h_re[(n - d) & 15], 1'b1);
            di = bf(h_im[(n - 2 * d) & 15], h_im[(n - d) & 15], 1'b1);
            k  = p << (s - 1);
            if (k == 0) begin
                re = dr;
                im = di;
            end else begin
                c   = qtw(k, 1'b0);
                ns  = qtw(k, 1'b1);
                re  = rsat(longint'(dr) * c - longint'(di) * ns);
                im  = rsat(longint'(dr) * ns + longint'(di) * c);
                tol = 1;
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp, input int tol);
        total++;
        if (act - exp > tol || exp - act > tol) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (tol %0d) at %0t", name, act, exp, tol, $time);
        end
    endtask

    task automatic check_inst(input int id, input string tag, input bit v, input bit ev,
                              input bit es, input int er, input int ei, input int tol,
                              input bit av, input bit as, input int ar, input int ai);
        chk({tag, "_valid"}, int'(av), v ? int'(ev) : 0, 0);
        chk({tag, "_start"}, int'(as), v ? int'(es) : 0, 0);
        if (v && ev) begin
            chk({tag, "_re"}, ar, er, tol);
            chk({tag, "_im"}, ai, ei, tol);
            hk[id] = 1; hr[id] = er; hi[id] = ei; ht[id] = tol;
        end else if (v) begin
            hk[id] = 0;
        end else if (hk[id]) begin
            chk({tag, "_hold_re"}, ar, hr[id], ht[id]);
            chk({tag, "_hold_im"}, ai, hi[id], ht[id]);
        end
    endtask

    task automatic cyc(input bit v, input bit st, input int re, input int im);
        bit e1v, e1s, e3v, e3s;
        int e1r, e1i, e3r, e3i, t1, t3;
        e1v = 0; e1s = 0; e3v = 0; e3s = 0;
        e1r = 0; e1i = 0; e3r = 0; e3i = 0; t1 = 0; t3 = 0;
        in_valid = v;
        in_start = st;
        in_re    = 16'(re);
        in_im    = 16'(im);
        if (v) begin
            if (st) n_cnt = 0;
            h_re[n_cnt & 15] = re;
            h_im[n_cnt & 15] = im;
            model(1, n_cnt, e1v, e1s, e1r, e1i, t1);
            model(3, n_cnt, e3v, e3s, e3r, e3i, t3);
            n_cnt++;
        end
        @(posedge clk);
        #1;
        check_inst(0, "s1", v, e1v, e1s, e1r, e1i, t1, o1_valid, o1_start, int'(o1_re), int'(o1_im));
        check_inst(1, "s3", v, e3v, e3s, e3r, e3i, t3, o3_valid, o3_start, int'(o3_re), int'(o3_im));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, int'(o1_valid), 0, 0);
        chk({tag, "_start"}, int'(o1_start), 0, 0);
        chk({tag, "_re"}, int'(o1_re), 0, 0);
        chk({tag, "_im"}, int'(o1_im), 0, 0);
        chk({tag, "_s3_valid"}, int'(o3_valid), 0, 0);
        chk({tag, "_s3_re"}, int'(o3_re), 0, 0);
        for (int i = 0; i < 2; i++) begin
            hk[i] = 1; hr[i] = 0; hi[i] = 0; ht[i] = 0;
        end
    endtask

    typedef struct {
        bit   v;
        bit   st;
        cpx_t x;
        bit   ev;
        bit   es;
        int   ere;
        int   eim;
        int   tol;
    } vec_t;

    vec_t tbl [24];

    initial begin
        int j;
        bit rv, rs;
        int rr, ri, amp;

        // Constant frame then flush, followed by a single-impulse frame then flush.
        for (int i = 0; i < 24; i++) begin
            j = i % 12;
            tbl[i].v  = 1'b1;
            tbl[i].st = (j == 0);
            tbl[i].x.im = '0;
            tbl[i].ev = (j >= 4);
            tbl[i].es = (j == 4);
            tbl[i].eim = 0;
            tbl[i].tol = 0;
            if (i < 12) begin
                tbl[i].x.re = (j < 8) ? 16'sd1000 : 16'sd0;
                tbl[i].ere  = (j >= 4 && j < 8) ? SUM2 : 0;
            end else begin
                tbl[i].x.re = (j == 1) ? 16'sd1000 : 16'sd0;
                tbl[i].ere  = (j == 5) ? S3 : ((j == 9) ? TW3 : 0);
                tbl[i].eim  = (j == 9) ? -TW3 : 0;
                tbl[i].tol  = (j == 9) ? 1 : 0;
            end
        end

        for (int i = 0; i < 2; i++) begin
            hk[i] = 0; hr[i] = 0; hi[i] = 0; ht[i] = 0;
        end
        for (int i = 0; i < 16; i++) begin
            h_re[i] = 0; h_im[i] = 0;
        end

        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");

        // Mid-stream reset, then a frame start on the release cycle.
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cyc(1'b1, i == 0, 300 + i, -50 * i);
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        n_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc(1'b1, i == 0, 10 * i, 0);
        chk("start_on_5th", int'(o1_start), 1, 0);
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            cyc(tbl[i].v, tbl[i].st, int'(tbl[i].x.re), int'(tbl[i].x.im));
            chk("tbl_valid", int'(o1_valid), int'(tbl[i].ev), 0);
            chk("tbl_start", int'(o1_start), int'(tbl[i].es), 0);
            if (tbl[i].ev) begin
                chk("tbl_re", int'(o1_re), tbl[i].ere, tbl[i].tol);
                chk("tbl_im", int'(o1_im), tbl[i].eim, tbl[i].tol);
            end
        end

        // Saturating (or exactly halved) butterfly at full scale.
        cyc(1'b1, 1'b1, 32767, -32768);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 0, 0);
        cyc(1'b1, 1'b0, 32767, -32768);
        chk("sat_re", int'(o1_re), 32767, 0);
        chk("sat_im", int'(o1_im), -32768, 0);
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 0, 0);

        // Impulse frame with a stall after every sample; stalls carry junk and a bogus start.
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, i == 0, (i == 1) ? 1000 : 0, 0);
            if (i == 9) chk("gap_tw_re", int'(o1_re), TW3, 1);
            cyc(1'b0, 1'b1, 12345, -999);
        end

        // Two-point stage: (100,30) pairs give (130,0) then (70,0).
        for (int r = 0; r < 5; r++) begin
            cyc(1'b1, r == 0, 100, 0);
            if (r > 0) begin
                chk("s3_diff_re", int'(o3_re), 70, 0);
                chk("s3_diff_valid", int'(o3_valid), 1, 0);
            end
            cyc(1'b1, 1'b0, 30, 0);
            chk("s3_sum_re", int'(o3_re), bf(100, 30, 1'b0), 0);
            chk("s3_sum_start", int'(o3_start), 1, 0);
        end

        for (int i = 0; i < 400; i++) begin
            rv  = ($urandom_range(0, 9) < 7);
            rs  = ($urandom_range(0, 39) == 0);
            amp = ($urandom_range(0, 1) == 0) ? 32768 : 2000;
            rr  = int'($urandom_range(0, 2 * amp - 1)) - amp;
            ri  = int'($urandom_range(0, 2 * amp - 1)) - amp;
            cyc(rv, rs, rr, ri);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
